dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store sequencer and round-robin two-port arbiter in front of
// a word-addressed data memory (combinational read, synchronous word write).
// Byte-addressed RISC-V core loads/stores and debug word accesses are turned
// into word accesses; sub-word stores are done as read-modify-write.
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   core_req/we/addr/wdata/funct3 -> core_done/rdata/err   core load/store
//   dbg_req/we/addr/wdata          -> dbg_done/rdata/err    debug word access
//   mem_we/mem_a/mem_wd, mem_rd                             data memory side
module dmem_ctrl #(
    parameter int unsigned MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_done,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;

    logic        last_dbg;      // last grant went to debug
    logic        srv_dbg;       // port currently being served
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic        any_req, gnt_dbg, sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_f3;

    logic [4:0]  sh;
    logic [31:0] lane, load_val, merge_val;
    logic        resp_set, resp_dbg, resp_err;
    logic [31:0] resp_data;

    // Request selection (round-robin on conflict) and legality check
    always_comb begin
        any_req   = core_req | dbg_req;
        gnt_dbg   = (core_req && dbg_req) ? ~last_dbg : dbg_req;
        sel_we    = gnt_dbg ? dbg_we    : core_we;
        sel_addr  = gnt_dbg ? dbg_addr  : core_addr;
        sel_wdata = gnt_dbg ? dbg_wdata : core_wdata;
        sel_f3    = gnt_dbg ? 3'b010    : core_funct3;
        sel_err   = 1'b0;
        case (sel_f3)
            3'b011, 3'b110, 3'b111: sel_err = 1'b1;
            default: ;
        endcase
        if (sel_we && sel_f3[2])                               sel_err = 1'b1;
        if (sel_f3[1:0] == 2'b01 && sel_addr[0])               sel_err = 1'b1;
        if (sel_f3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00)    sel_err = 1'b1;
        if (sel_addr[31:2] >= 30'(MEM_SIZE))                   sel_err = 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = sel_err ? RESP : READ;
            READ:    state_nx = we_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs: write strobe only in WRITE, so reset kills it at once
    always_comb begin
        mem_we = (state == WRITE);
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        sh   = {addr_q[1:0], 3'b000};
        lane = mem_rd >> sh;
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_val = mem_rd;
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = 32'h0;
        endcase
        case (f3_q[1:0])
            2'b00:   merge_val = (mem_rd & ~(32'h0000_00FF << sh)) | ({24'h0, wdata_q[7:0]} << sh);
            2'b01:   merge_val = (mem_rd & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata_q[15:0]} << sh);
            default: merge_val = wdata_q;
        endcase
    end

    // Response generated on every transition into RESP
    always_comb begin
        resp_set  = 1'b0;
        resp_err  = 1'b0;
        resp_data = 32'h0;
        resp_dbg  = (state == IDLE) ? gnt_dbg : srv_dbg;
        case (state)
            IDLE:  if (any_req && sel_err) begin resp_set = 1'b1; resp_err = 1'b1; end
            READ:  if (!we_q) begin resp_set = 1'b1; resp_data = load_val; end
            WRITE: resp_set = 1'b1;
            default: ;
        endcase
    end

    // Request latches, memory address/data and per-port response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dbg   <= 1'b1;
            srv_dbg    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            f3_q       <= 3'b000;
            mem_a      <= 32'h0;
            mem_wd     <= 32'h0;
            core_done  <= 1'b0;
            core_rdata <= 32'h0;
            core_err   <= 1'b0;
            dbg_done   <= 1'b0;
            dbg_rdata  <= 32'h0;
            dbg_err    <= 1'b0;
        end else begin
            core_done <= 1'b0;
            dbg_done  <= 1'b0;
            if (state == IDLE && any_req) begin
                srv_dbg  <= gnt_dbg;
                last_dbg <= gnt_dbg;
                we_q     <= sel_we;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
                f3_q     <= sel_f3;
                if (!sel_err) mem_a <= {2'b00, sel_addr[31:2]};
            end
            if (state == READ && we_q) mem_wd <= merge_val;
            if (resp_set) begin
                if (resp_dbg) begin
                    dbg_done  <= 1'b1;
                    dbg_rdata <= resp_data;
                    dbg_err   <= resp_err;
                end else begin
                    core_done  <= 1'b1;
                    core_rdata <= resp_data;
                    core_err   <= resp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural data memory and a response
// scoreboard (expected port/rdata/err/cycle pushed at drive time).
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
    logic [2:0]  core_funct3 = 3'b000;
    logic        core_done, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
    logic        dbg_done, dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];

    typedef struct {
        bit          port;   // 0 core, 1 dbg
        logic [31:0] rdata;
        logic        err;
        int          cyc;    // expected done cycle from run start, -1 = unchecked
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int we_cnt, we_cyc;
    logic [31:0] we_a, we_d;

    dmem_ctrl #(.MEM_SIZE(64)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_done(core_done), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, synchronous write
    always_comb mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'h0;
    always @(posedge clk) if (mem_we && mem_a < 32'd64) mem[mem_a[5:0]] <= mem_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] rd, input logic err, input int cyc);
        exp_t e;
        e.port = port; e.rdata = rd; e.err = err; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drive_core(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] f3);
        @(posedge clk); #1;
        core_we = we; core_addr = a; core_wdata = wd; core_funct3 = f3; core_req = 1'b1;
    endtask

    task automatic drive_dbg(input logic we, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
    endtask

    task automatic drive_both(input logic [31:0] ca, input logic [31:0] da);
        @(posedge clk); #1;
        core_we = 1'b0; core_addr = ca; core_funct3 = 3'b010; core_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = da; dbg_req = 1'b1;
    endtask

    // Watch negedges until ndone responses arrive, comparing each against the scoreboard
    task automatic run(input string tag, input int ndone, input bit keep);
        int   cyc = 0;
        int   got = 0;
        exp_t e;
        bit   p;
        we_cnt = 0; we_cyc = -1; we_a = 32'h0; we_d = 32'h0;
        while (got < ndone && cyc < 40) begin
            @(negedge clk);
            if (mem_we) begin we_cnt++; we_cyc = cyc; we_a = mem_a; we_d = mem_wd; end
            if (core_done || dbg_done) begin
                p = dbg_done;
                if (sb.size() == 0) begin
                    check({tag, "_unexpected_done"}, 32'(p), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_port"}, 32'(p), 32'(e.port));
                    check({tag, "_rdata"}, p ? dbg_rdata : core_rdata, e.rdata);
                    check({tag, "_err"}, 32'(p ? dbg_err : core_err), 32'(e.err));
                    if (e.cyc >= 0) check({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
                end
                if (!keep) begin
                    if (p) dbg_req = 1'b0;
                    else   core_req = 1'b0;
                end
                got++;
            end
            cyc++;
        end
        if (got < ndone) check({tag, "_timeout"}, 32'(got), 32'(ndone));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);

        // Reset values
        #2;
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_core_done", 32'(core_done), 32'h0);
        check("rst_core_rdata", core_rdata, 32'h0);
        check("rst_dbg_err", 32'(dbg_err), 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Word store then load
        push(1'b0, 32'h0, 1'b0, 3);
        drive_core(1'b1, 32'h8, 32'hDEAD_BEEF, 3'b010);
        run("sw", 1, 1'b0);
        check("sw_we_cnt", 32'(we_cnt), 32'd1);
        check("sw_we_cyc", 32'(we_cyc), 32'd2);
        check("sw_mem_a", we_a, 32'd2);
        check("sw_mem_wd", we_d, 32'hDEAD_BEEF);
        check("sw_mem", mem[2], 32'hDEAD_BEEF);

        push(1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        drive_core(1'b0, 32'h8, 32'h0, 3'b010);
        run("lw", 1, 1'b0);
        check("lw_we_cnt", 32'(we_cnt), 32'd0);

        // Sub-word stores
        push(1'b0, 32'h0, 1'b0, 3);
        drive_core(1'b1, 32'hA, 32'hFFFF_FF55, 3'b000);
        run("sb", 1, 1'b0);
        check("sb_mem_wd", we_d, 32'hDE55_BEEF);
        push(1'b0, 32'h0, 1'b0, 3);
        drive_core(1'b1, 32'h8, 32'hABCD_1234, 3'b001);
        run("sh", 1, 1'b0);
        check("sh_mem_wd", we_d, 32'hDE55_1234);
        check("sh_mem", mem[2], 32'hDE55_1234);

        // Sign/zero extension
        push(1'b0, 32'hFFFF_FFDE, 1'b0, 2);
        drive_core(1'b0, 32'hB, 32'h0, 3'b000);
        run("lb", 1, 1'b0);
        push(1'b0, 32'h0000_00DE, 1'b0, 2);
        drive_core(1'b0, 32'hB, 32'h0, 3'b100);
        run("lbu", 1, 1'b0);
        push(1'b0, 32'hFFFF_DE55, 1'b0, 2);
        drive_core(1'b0, 32'hA, 32'h0, 3'b001);
        run("lh", 1, 1'b0);
        push(1'b0, 32'h0000_1234, 1'b0, 2);
        drive_core(1'b0, 32'h8, 32'h0, 3'b101);
        run("lhu", 1, 1'b0);

        // Error cases: done in cycle 1, no memory write
        push(1'b0, 32'h0, 1'b1, 1);
        drive_core(1'b0, 32'h6, 32'h0, 3'b010);
        run("err_lw_mis", 1, 1'b0);
        check("err_lw_mis_we", 32'(we_cnt), 32'd0);
        push(1'b0, 32'h0, 1'b1, 1);
        drive_core(1'b1, 32'h9, 32'h7777, 3'b001);
        run("err_sh_mis", 1, 1'b0);
        check("err_sh_mis_we", 32'(we_cnt), 32'd0);
        push(1'b0, 32'h0, 1'b1, 1);
        drive_core(1'b0, 32'h8, 32'h0, 3'b011);
        run("err_f3", 1, 1'b0);
        push(1'b0, 32'h0, 1'b1, 1);
        drive_core(1'b0, 32'h100, 32'h0, 3'b010);
        run("err_range", 1, 1'b0);
        push(1'b0, 32'h0, 1'b1, 1);
        drive_core(1'b1, 32'h8, 32'h99, 3'b100);
        run("err_sbu", 1, 1'b0);
        check("err_sbu_we", 32'(we_cnt), 32'd0);
        check("err_mem_unchanged", mem[2], 32'hDE55_1234);

        // Debug port word accesses
        push(1'b1, 32'h0, 1'b0, 3);
        drive_dbg(1'b1, 32'h10, 32'hCAFE_F00D);
        run("dbg_w", 1, 1'b0);
        check("dbg_w_mem", mem[4], 32'hCAFE_F00D);
        push(1'b1, 32'hCAFE_F00D, 1'b0, 2);
        drive_dbg(1'b0, 32'h10, 32'h0);
        run("dbg_r", 1, 1'b0);
        push(1'b1, 32'h0, 1'b1, 1);
        drive_dbg(1'b0, 32'h2, 32'h0);
        run("dbg_err", 1, 1'b0);

        // Simultaneous requests from reset: core first, then debug
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        push(1'b0, 32'hDE55_1234, 1'b0, 2);
        push(1'b1, 32'hCAFE_F00D, 1'b0, 5);
        drive_both(32'h8, 32'h10);
        run("arb", 2, 1'b0);

        // Both held: grants alternate core, dbg, core, dbg
        push(1'b0, 32'hDE55_1234, 1'b0, 2);
        push(1'b1, 32'hCAFE_F00D, 1'b0, 5);
        push(1'b0, 32'hDE55_1234, 1'b0, 8);
        push(1'b1, 32'hCAFE_F00D, 1'b0, 11);
        drive_both(32'h8, 32'h10);
        run("alt", 4, 1'b1);
        core_req = 1'b0; dbg_req = 1'b0;

        // Reset during WRITE: strobe drops at once, no done, no write
        drive_core(1'b1, 32'h14, 32'h1111_1111, 3'b010);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("midrst_we_before", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_we_after", 32'(mem_we), 32'h0);
        check("midrst_mem_a", mem_a, 32'h0);
        check("midrst_done", 32'(core_done), 32'h0);
        core_req = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_done_hold", 32'(core_done), 32'h0);
        reset = 1'b0;
        check("midrst_mem", mem[5], 32'h1000_0005);
        push(1'b0, 32'hDE55_1234, 1'b0, 2);
        push(1'b1, 32'hCAFE_F00D, 1'b0, 5);
        drive_both(32'h8, 32'h10);
        run("arb_after_rst", 2, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
